// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: write-back select codes,
// FSM state encoding and the MEM/WB record with its bubble value.
package mem_stage_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    localparam logic [1:0] MD_ALU  = 2'b00;
    localparam logic [1:0] MD_LOAD = 2'b01;
    localparam logic [1:0] MD_SLT  = 2'b10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic            rw;
        logic [REGW-1:0] da;
        logic [1:0]      md;
        logic            nxorv;
        logic [XLEN-1:0] f;
        logic [XLEN-1:0] data;
    } memwb_t;

    localparam memwb_t MEMWB_BUBBLE = '0;

endpackage

// File: rtl/mem_if.sv
// Ready/ack data-memory port between the memory stage (master) and memory.
// Signals: mem_req/mem_we/mem_addr/mem_wdata out of master, mem_rdata/mem_ack in.
interface mem_if #(
    parameter int DW = 32
) ();
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_stage_mem_wb_reg.sv
// MEM/WB pipeline register. Ports: clk, rst, load_i (capture d_i),
// bubble_i (capture the empty record, wins over load_i), d_i, q_o.
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load_i,
    input  logic   bubble_i,
    input  memwb_t d_i,
    output memwb_t q_o
);
    memwb_t q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= MEMWB_BUBBLE;
        end else if (bubble_i) begin
            q_q <= MEMWB_BUBBLE;
        end else if (load_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores on a ready/ack port, stalls
// upstream while outstanding, and drives the MEM/WB register.
// Ports: clk/rst, EX/MEM operands + flush in, stall out, mem (master
// port), mem_err pulse, *_wb write-back record out.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DW          = 32,
    parameter int AW          = 5,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          RW,
    input  logic [AW-1:0] DA,
    input  logic [1:0]    MD,
    input  logic          MW,
    input  logic          NxorV,
    input  logic [DW-1:0] F,
    input  logic [DW-1:0] BusB,
    input  logic          flush,
    output logic          stall,
    mem_if.master         mem,
    output logic          mem_err,
    output logic          RW_wb,
    output logic [AW-1:0] DA_wb,
    output logic [1:0]    MD_wb,
    output logic          NxorV_wb,
    output logic [DW-1:0] F_wb,
    output logic [DW-1:0] Data_out_wb
);
    localparam int CW = $clog2(ACK_TIMEOUT + 2);

    state_e        state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic          drop_q, drop_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    memwb_t        hold_q, hold_d;
    memwb_t        wb_d, wb_q;
    logic          wb_bubble;

    logic is_mem, accept, done, tmo;

    assign is_mem = (MD == MD_LOAD) | MW;
    assign accept = (state_q == S_IDLE) & in_valid & is_mem & ~flush;
    assign done   = (state_q == S_WAIT) & mem.mem_ack;
    // ack in the final cycle still wins over the timeout
    assign tmo    = (state_q == S_WAIT) & ~mem.mem_ack
                  & (cnt_q == CW'(ACK_TIMEOUT));

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = S_WAIT;
            S_WAIT: if (done | tmo) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // outputs and datapath next values
    always_comb begin
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        drop_d    = drop_q;
        hold_d    = hold_q;
        err_d     = 1'b0;
        wb_d      = MEMWB_BUBBLE;
        wb_bubble = 1'b1;
        stall     = ~rst & in_valid & is_mem & ~(done | tmo);
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    req_d   = 1'b1;
                    we_d    = MW;
                    addr_d  = {F[DW-1:2], 2'b00};
                    wdata_d = BusB;
                    cnt_d   = '0;
                    drop_d  = 1'b0;
                    hold_d  = '{rw: RW, da: DA, md: MD,
                                nxorv: NxorV, f: F, data: '0};
                end else if (in_valid & ~is_mem & ~flush) begin
                    wb_bubble = 1'b0;
                    wb_d      = '{rw: RW, da: DA, md: MD,
                                  nxorv: NxorV, f: F, data: '0};
                end
            end
            S_WAIT: begin
                cnt_d  = cnt_q + 1'b1;
                // a flush cannot abort the bus cycle, only its result
                drop_d = drop_q | flush;
                if (done | tmo) begin
                    req_d  = 1'b0;
                    cnt_d  = '0;
                    drop_d = 1'b0;
                    err_d  = tmo;
                end
                if (done & ~(drop_q | flush)) begin
                    wb_bubble = 1'b0;
                    wb_d      = hold_q;
                    wb_d.data = (hold_q.md == MD_LOAD) ? mem.mem_rdata : '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            hold_q  <= MEMWB_BUBBLE;
        end else begin
            req_q   <= req_d;
            we_q    <= we_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk      (clk),
        .rst      (rst),
        .load_i   (1'b1),
        .bubble_i (wb_bubble),
        .d_i      (wb_d),
        .q_o      (wb_q)
    );

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem_err       = err_q;

    assign RW_wb       = wb_q.rw;
    assign DA_wb       = wb_q.da;
    assign MD_wb       = wb_q.md;
    assign NxorV_wb    = wb_q.nxorv;
    assign F_wb        = wb_q.f;
    assign Data_out_wb = wb_q.data;
endmodule
